// File: rtl/noc_traffic_pkg.sv
// Shared constants for the NoC traffic node: header field layout and FSM state encodings.
package noc_traffic_pkg;

    localparam int SEQ_W = 8;
    localparam int LEN_W = 8;

    // Header layout, low to high: dest_x, dest_y, src_x, src_y, seq, len.
    function automatic int hdr_dx_lsb(input int c);
        return 0;
    endfunction

    function automatic int hdr_dy_lsb(input int c);
        return c;
    endfunction

    function automatic int hdr_sx_lsb(input int c);
        return 2 * c;
    endfunction

    function automatic int hdr_sy_lsb(input int c);
        return 3 * c;
    endfunction

    function automatic int hdr_seq_lsb(input int c);
        return 4 * c;
    endfunction

    function automatic int hdr_len_lsb(input int c);
        return 4 * c + SEQ_W;
    endfunction

    typedef logic [1:0] snd_state_t;
    localparam snd_state_t SND_WAIT = 2'd0;
    localparam snd_state_t SND_SEND = 2'd1;
    localparam snd_state_t SND_GAP  = 2'd2;
    localparam snd_state_t SND_DONE = 2'd3;

    typedef logic [0:0] chk_state_t;
    localparam chk_state_t CHK_IDLE = 1'b0;
    localparam chk_state_t CHK_BODY = 1'b1;

endpackage

// File: rtl/noc_traffic_node_if.sv
// Flit link between the traffic node and one router local port (both directions).
interface noc_traffic_node_if #(
    parameter int DATA_W = 32
);
    logic              receive_valid;
    logic [DATA_W-1:0] receive_flit;
    logic              receive_is_header;
    logic              receive_is_tail;
    logic              receive_ready;

    logic              sender_valid;
    logic [DATA_W-1:0] sender_flit;
    logic              sender_is_header;
    logic              sender_is_tail;
    logic              sender_ready;

    // master = endpoint side, slave = router side
    modport master (
        input  receive_valid, receive_flit, receive_is_header, receive_is_tail,
        output receive_ready,
        output sender_valid, sender_flit, sender_is_header, sender_is_tail,
        input  sender_ready
    );

    modport slave (
        output receive_valid, receive_flit, receive_is_header, receive_is_tail,
        input  receive_ready,
        input  sender_valid, sender_flit, sender_is_header, sender_is_tail,
        output sender_ready
    );
endinterface

// File: rtl/noc_traffic_checker.sv
// Receive side of the traffic node: packet checker, receive/error counters and ready generation.
// Optional NOC_TRAFFIC_BACKPRESSURE_EN drives receive_ready from an 8-bit LFSR.
module noc_traffic_checker
    import noc_traffic_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 4,
    parameter int X_ID    = 0,
    parameter int Y_ID    = 0,
    parameter int CNT_W   = 8
) (
    input  logic              noc_clk,
    input  logic              noc_rst_n,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_flit,
    input  logic              rx_is_header,
    input  logic              rx_is_tail,
    output logic              rx_ready,
    output logic [CNT_W-1:0]  receive_num,
    output logic [CNT_W-1:0]  err_num
);
    localparam int DX_LSB  = hdr_dx_lsb(COORD_W);
    localparam int DY_LSB  = hdr_dy_lsb(COORD_W);
    localparam int SEQ_LSB = hdr_seq_lsb(COORD_W);
    localparam int LEN_LSB = hdr_len_lsb(COORD_W);

    chk_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [7:0]        idx_q, idx_d;
    logic              pkt_err_q, pkt_err_d;
    logic              rdy_en_q, rdy_en_d;
    logic [CNT_W-1:0]  receive_num_q, receive_num_d;
    logic [CNT_W-1:0]  err_num_q, err_num_d;

    logic              fire;
    logic              dest_bad;
    logic              last_flit;
    logic              mismatch;
    logic              err_inc;
    logic              recv_inc;
    logic [LEN_W-1:0]  hdr_len;
    logic [SEQ_W-1:0]  hdr_seq;
    logic [DATA_W-1:0] exp_flit;

    assign fire      = rx_valid && rx_ready;
    assign hdr_len   = rx_flit[LEN_LSB +: LEN_W];
    assign hdr_seq   = rx_flit[SEQ_LSB +: SEQ_W];
    assign dest_bad  = (rx_flit[DX_LSB +: COORD_W] != COORD_W'(X_ID)) ||
                       (rx_flit[DY_LSB +: COORD_W] != COORD_W'(Y_ID));
    assign exp_flit  = DATA_W'({seq_q, idx_q});
    assign mismatch  = (rx_flit != exp_flit);
    assign last_flit = (idx_q == len_q - 8'd1);
    assign rdy_en_d  = 1'b1;

    // pkt_err_q suppresses further error counts until the packet ends.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        seq_d     = seq_q;
        idx_d     = idx_q;
        pkt_err_d = pkt_err_q;
        err_inc   = 1'b0;
        recv_inc  = 1'b0;
        if (fire) begin
            if (rx_is_header) begin
                err_inc   = dest_bad || (state_q == CHK_BODY && !pkt_err_q);
                len_d     = hdr_len;
                seq_d     = hdr_seq;
                idx_d     = 8'd1;
                pkt_err_d = dest_bad;
                if (hdr_len <= 8'd1) begin
                    state_d = CHK_IDLE;
                    if (!rx_is_tail)    err_inc  = 1'b1;
                    else if (!dest_bad) recv_inc = 1'b1;
                end else if (rx_is_tail) begin
                    state_d = CHK_IDLE;
                    err_inc = 1'b1;
                end else begin
                    state_d = CHK_BODY;
                end
            end else if (state_q == CHK_IDLE) begin
                err_inc = 1'b1;
            end else if (rx_is_tail || last_flit) begin
                state_d = CHK_IDLE;
                if (rx_is_tail && last_flit && !mismatch) recv_inc = !pkt_err_q;
                else                                      err_inc  = !pkt_err_q;
            end else begin
                idx_d = idx_q + 8'd1;
                if (mismatch) begin
                    err_inc   = !pkt_err_q;
                    pkt_err_d = 1'b1;
                end
            end
        end
        receive_num_d = (recv_inc && !(&receive_num_q)) ? receive_num_q + 1'b1 : receive_num_q;
        err_num_d     = (err_inc && !(&err_num_q)) ? err_num_q + 1'b1 : err_num_q;
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q       <= CHK_IDLE;
            len_q         <= '0;
            seq_q         <= '0;
            idx_q         <= '0;
            pkt_err_q     <= 1'b0;
            rdy_en_q      <= 1'b0;
            receive_num_q <= '0;
            err_num_q     <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            seq_q         <= seq_d;
            idx_q         <= idx_d;
            pkt_err_q     <= pkt_err_d;
            rdy_en_q      <= rdy_en_d;
            receive_num_q <= receive_num_d;
            err_num_q     <= err_num_d;
        end
    end

`ifdef NOC_TRAFFIC_BACKPRESSURE_EN
    // x^8+x^6+x^5+x^4+1, shifting left; stall whenever the two low bits are zero.
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) lfsr_q <= 8'hA5;
        else            lfsr_q <= lfsr_d;
    end

    assign rx_ready = rdy_en_q && (lfsr_q[1:0] != 2'b00);
`else
    assign rx_ready = rdy_en_q;
`endif

    assign receive_num = receive_num_q;
    assign err_num     = err_num_q;

endmodule

// File: rtl/noc_traffic_node.sv
// NoC traffic endpoint: sender FSM generating NUM_PKTS packets plus the receive checker.
// Build option NOC_TRAFFIC_BACKPRESSURE_EN (see noc_traffic_checker) adds receive backpressure.
module noc_traffic_node
    import noc_traffic_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int COORD_W     = 4,
    parameter int X_ID        = 0,
    parameter int Y_ID        = 0,
    parameter int DEST_X_ID   = 1,
    parameter int DEST_Y_ID   = 1,
    parameter int PKT_LEN     = 4,
    parameter int NUM_PKTS    = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int START_DELAY = 16,
    parameter int CNT_W       = 8
) (
    input  logic               noc_clk,
    input  logic               noc_rst_n,
    noc_traffic_node_if.master bus,
    output logic [CNT_W-1:0]   receive_num,
    output logic [CNT_W-1:0]   send_num,
    output logic [CNT_W-1:0]   err_num,
    output logic               send_done
);
    localparam int DLY_W   = 16;
    localparam int DX_LSB  = hdr_dx_lsb(COORD_W);
    localparam int DY_LSB  = hdr_dy_lsb(COORD_W);
    localparam int SX_LSB  = hdr_sx_lsb(COORD_W);
    localparam int SY_LSB  = hdr_sy_lsb(COORD_W);
    localparam int SEQ_LSB = hdr_seq_lsb(COORD_W);
    localparam int LEN_LSB = hdr_len_lsb(COORD_W);

    snd_state_t        state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [7:0]        idx_q, idx_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [CNT_W-1:0]  send_num_q, send_num_d;

    logic              valid;
    logic              is_tail;
    logic              fire;
    logic [DATA_W-1:0] flit;

    assign valid   = (state_q == SND_SEND);
    assign is_tail = valid && (idx_q == 8'(PKT_LEN - 1));
    assign fire    = valid && bus.sender_ready;

    // Flit content depends only on idx_q/seq_q, which move only on acceptance, so it holds while stalled.
    always_comb begin
        flit = '0;
        if (idx_q == 8'd0) begin
            flit[DX_LSB  +: COORD_W] = COORD_W'(DEST_X_ID);
            flit[DY_LSB  +: COORD_W] = COORD_W'(DEST_Y_ID);
            flit[SX_LSB  +: COORD_W] = COORD_W'(X_ID);
            flit[SY_LSB  +: COORD_W] = COORD_W'(Y_ID);
            flit[SEQ_LSB +: SEQ_W]   = seq_q;
            flit[LEN_LSB +: LEN_W]   = LEN_W'(PKT_LEN);
        end else begin
            flit = DATA_W'({seq_q, idx_q});
        end
    end

    // NOTE: every _d gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        send_num_d = send_num_q;
        case (state_q)
            SND_WAIT: begin
                if (dly_q == DLY_W'(START_DELAY)) begin
                    state_d = SND_SEND;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            SND_SEND: begin
                if (fire && is_tail) begin
                    idx_d      = '0;
                    seq_d      = seq_q + 8'd1;
                    send_num_d = (&send_num_q) ? send_num_q : send_num_q + 1'b1;
                    if (NUM_PKTS != 0 && int'(send_num_q) + 1 == NUM_PKTS) state_d = SND_DONE;
                    else if (GAP_CYCLES == 0)                              state_d = SND_SEND;
                    else                                                   state_d = SND_GAP;
                end else if (fire) begin
                    idx_d = idx_q + 8'd1;
                end
            end
            SND_GAP: begin
                if (dly_q == DLY_W'(GAP_CYCLES - 1)) begin
                    state_d = SND_SEND;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q    <= SND_WAIT;
            dly_q      <= '0;
            idx_q      <= '0;
            seq_q      <= '0;
            send_num_q <= '0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            send_num_q <= send_num_d;
        end
    end

    assign bus.sender_valid     = valid;
    assign bus.sender_flit      = valid ? flit : '0;
    assign bus.sender_is_header = valid && (idx_q == 8'd0);
    assign bus.sender_is_tail   = is_tail;
    assign send_num             = send_num_q;
    assign send_done            = (state_q == SND_DONE);

    noc_traffic_checker #(
        .DATA_W  (DATA_W),
        .COORD_W (COORD_W),
        .X_ID    (X_ID),
        .Y_ID    (Y_ID),
        .CNT_W   (CNT_W)
    ) u_checker (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .rx_valid     (bus.receive_valid),
        .rx_flit      (bus.receive_flit),
        .rx_is_header (bus.receive_is_header),
        .rx_is_tail   (bus.receive_is_tail),
        .rx_ready     (bus.receive_ready),
        .receive_num  (receive_num),
        .err_num      (err_num)
    );

endmodule

// File: tb/tb_noc_traffic_node.sv
// Bench for noc_traffic_node: node A (4-flit packets, loopback or injected), node B (single-flit, endless).
module tb_noc_traffic_node;

    typedef struct packed {
        logic [31:0] flit;
        logic        h;
        logic        t;
    } exp_t;

    logic noc_clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];

    logic        loop_a    = 1'b1;
    logic        tb_rdy_a  = 1'b0;
    logic        inj_valid = 1'b0;
    logic        inj_hdr   = 1'b0;
    logic        inj_tail  = 1'b0;
    logic [31:0] inj_flit  = '0;

    logic [7:0] a_recv, a_send, a_err, b_recv, b_send, b_err;
    logic       a_done, b_done;

    always #5 noc_clk = ~noc_clk;

    noc_traffic_node_if #(.DATA_W(32)) a_if ();
    noc_traffic_node_if #(.DATA_W(32)) b_if ();

    // Bench acts as the router: loop A's sender back into its receiver, or inject flits directly.
    assign a_if.sender_ready      = loop_a ? (tb_rdy_a & a_if.receive_ready) : tb_rdy_a;
    assign a_if.receive_valid     = loop_a ? (a_if.sender_valid & tb_rdy_a) : inj_valid;
    assign a_if.receive_flit      = loop_a ? a_if.sender_flit : inj_flit;
    assign a_if.receive_is_header = loop_a ? a_if.sender_is_header : inj_hdr;
    assign a_if.receive_is_tail   = loop_a ? a_if.sender_is_tail : inj_tail;

    assign b_if.sender_ready      = b_if.receive_ready;
    assign b_if.receive_valid     = b_if.sender_valid;
    assign b_if.receive_flit      = b_if.sender_flit;
    assign b_if.receive_is_header = b_if.sender_is_header;
    assign b_if.receive_is_tail   = b_if.sender_is_tail;

    noc_traffic_node #(
        .DATA_W(32), .COORD_W(4), .X_ID(1), .Y_ID(1), .DEST_X_ID(1), .DEST_Y_ID(1),
        .PKT_LEN(4), .NUM_PKTS(3), .GAP_CYCLES(2), .START_DELAY(16), .CNT_W(8)
    ) dut_a (
        .noc_clk(noc_clk), .noc_rst_n(rst_a_n), .bus(a_if),
        .receive_num(a_recv), .send_num(a_send), .err_num(a_err), .send_done(a_done)
    );

    noc_traffic_node #(
        .DATA_W(32), .COORD_W(4), .X_ID(2), .Y_ID(2), .DEST_X_ID(2), .DEST_Y_ID(2),
        .PKT_LEN(1), .NUM_PKTS(0), .GAP_CYCLES(0), .START_DELAY(3), .CNT_W(8)
    ) dut_b (
        .noc_clk(noc_clk), .noc_rst_n(rst_b_n), .bus(b_if),
        .receive_num(b_recv), .send_num(b_send), .err_num(b_err), .send_done(b_done)
    );

    function automatic logic [31:0] mk_hdr(input int dx, input int dy, input int sx, input int sy,
                                           input int seq, input int len);
        return 32'(dx) | (32'(dy) << 4) | (32'(sx) << 8) | (32'(sy) << 12) |
               (32'(seq & 255) << 16) | (32'(len & 255) << 24);
    endfunction

    function automatic logic [31:0] mk_body(input int seq, input int k);
        return (32'(seq & 255) << 8) | 32'(k & 255);
    endfunction

    task automatic push_pkts_a(input int n_pkts, input int seq0);
        exp_t e;
        for (int p = 0; p < n_pkts; p++) begin
            for (int k = 0; k < 4; k++) begin
                e.flit = (k == 0) ? mk_hdr(1, 1, 1, 1, seq0 + p, 4) : mk_body(seq0 + p, k);
                e.h    = (k == 0);
                e.t    = (k == 3);
                sb_a.push_back(e);
            end
        end
    endtask

    // Releases A's reset between edges and returns the edge index on which sender_valid first rises.
    task automatic release_a(output int edge_n);
        edge_n = 0;
        @(negedge noc_clk);
        rst_a_n = 1'b1;
        #1;
        checks++;
        if (a_if.receive_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge1 got=%b exp=0", a_if.receive_ready);
        end
        for (int i = 1; i <= 40; i++) begin
            @(posedge noc_clk);
            #1;
            if (i == 1) begin
                checks++;
                if (a_if.receive_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_edge1 got=%b exp=1", a_if.receive_ready);
                end
            end
            if (a_if.sender_valid) begin
                edge_n = i;
                break;
            end
        end
    endtask

    task automatic pulse_reset_a();
        @(negedge noc_clk);
        tb_rdy_a = 1'b0;
        rst_a_n  = 1'b0;
        @(negedge noc_clk);
        rst_a_n  = 1'b1;
    endtask

    // Drives sender_ready (mode 0: held high, mode 1: toggling) and scores n_flits sender transfers.
    task automatic run_a(input int mode, input int n_flits, input int budget);
        int   popped;
        logic have_hold;
        exp_t held, got, e;
        popped    = 0;
        have_hold = 1'b0;
        for (int c = 0; c < budget && popped < n_flits; c++) begin
            @(negedge noc_clk);
            tb_rdy_a = (mode == 1 && c > 0) ? ~tb_rdy_a : 1'b1;
            #1;
            got = {a_if.sender_flit, a_if.sender_is_header, a_if.sender_is_tail};
            if (have_hold) begin
                checks++;
                if (a_if.sender_valid !== 1'b1 || got !== held) begin
                    errors++;
                    $display("FAIL stall_hold got=%b/%h exp=1/%h", a_if.sender_valid, got, held);
                end
            end
            have_hold = 1'b0;
            if (a_if.sender_valid && a_if.sender_ready) begin
                checks++;
                if (sb_a.size() == 0) begin
                    errors++;
                    $display("FAIL extra_flit got=%h exp=none", got);
                end else begin
                    e = sb_a.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL flit_a[%0d] got=%h/%b/%b exp=%h/%b/%b",
                                 popped, got.flit, got.h, got.t, e.flit, e.h, e.t);
                    end
                end
                popped++;
            end else if (a_if.sender_valid) begin
                held      = got;
                have_hold = 1'b1;
            end
        end
        if (popped < n_flits) begin
            checks++;
            errors++;
            $display("FAIL run_a_timeout got=%0d exp=%0d flits", popped, n_flits);
        end
    endtask

    task automatic inject(input logic [31:0] f, input logic h, input logic t);
        logic ok;
        ok = 1'b0;
        @(negedge noc_clk);
        inj_valid = 1'b1;
        inj_flit  = f;
        inj_hdr   = h;
        inj_tail  = t;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (a_if.receive_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge noc_clk);
        end
        if (ok) begin
            @(posedge noc_clk);
        end else begin
            checks++;
            errors++;
            $display("FAIL inject_timeout got=ready0 exp=ready1");
        end
    endtask

    task automatic inject_idle();
        @(negedge noc_clk);
        inj_valid = 1'b0;
        inj_hdr   = 1'b0;
        inj_tail  = 1'b0;
        inj_flit  = '0;
        repeat (3) @(negedge noc_clk);
    endtask

    task automatic check_a_counts(input string tag, input int exp_recv, input int exp_send, input int exp_err);
        checks++;
        if (a_recv !== 8'(exp_recv)) begin
            errors++;
            $display("FAIL %s_receive_num got=%0d exp=%0d", tag, a_recv, exp_recv);
        end
        checks++;
        if (a_send !== 8'(exp_send)) begin
            errors++;
            $display("FAIL %s_send_num got=%0d exp=%0d", tag, a_send, exp_send);
        end
        checks++;
        if (a_err !== 8'(exp_err)) begin
            errors++;
            $display("FAIL %s_err_num got=%0d exp=%0d", tag, a_err, exp_err);
        end
    endtask

    task automatic test_reset();
        int n;
        #12;
        checks++;
        if ({a_if.sender_valid, a_if.sender_flit, a_if.sender_is_header, a_if.sender_is_tail,
             a_if.receive_ready, a_recv, a_send, a_err, a_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_a got=nonzero exp=0 (valid=%b ready=%b)",
                     a_if.sender_valid, a_if.receive_ready);
        end
        checks++;
        if ({b_if.sender_valid, b_if.sender_flit, b_if.receive_ready, b_recv, b_send, b_err, b_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_b got=nonzero exp=0");
        end
        release_a(n);
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL first_header_edge got=%0d exp=17", n);
        end
    endtask

    task automatic test_loopback();
        push_pkts_a(3, 0);
        run_a(0, 12, 400);
        repeat (4) @(negedge noc_clk);
        check_a_counts("loopback", 3, 3, 0);
        checks++;
        if (a_done !== 1'b1 || a_if.sender_valid !== 1'b0) begin
            errors++;
            $display("FAIL loopback_done got=%b/%b exp=1/0", a_done, a_if.sender_valid);
        end
    endtask

    task automatic test_backpressure();
        pulse_reset_a();
        sb_a.delete();
        push_pkts_a(3, 0);
        run_a(1, 12, 600);
        repeat (6) @(negedge noc_clk);
        check_a_counts("backpressure", 3, 3, 0);
        checks++;
        if (a_done !== 1'b1 || a_if.sender_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_done got=%b/%b exp=1/0", a_done, a_if.sender_valid);
        end
    endtask

    task automatic test_wrong_dest();
        loop_a = 1'b0;
        inject(mk_hdr(2, 3, 1, 1, 9, 4), 1'b1, 1'b0);
        inject(mk_body(9, 1), 1'b0, 1'b0);
        inject(mk_body(9, 2), 1'b0, 1'b0);
        inject(mk_body(9, 3), 1'b0, 1'b1);
        inject_idle();
        check_a_counts("wrong_dest", 3, 3, 1);
    endtask

    task automatic test_truncated();
        pulse_reset_a();
        inject(mk_hdr(1, 1, 0, 0, 5, 4), 1'b1, 1'b0);
        inject(mk_body(5, 1), 1'b0, 1'b0);
        inject(mk_body(5, 2), 1'b0, 1'b1);
        inject_idle();
        check_a_counts("truncated", 0, 0, 1);
        inject(mk_hdr(1, 1, 0, 0, 6, 4), 1'b1, 1'b0);
        for (int k = 1; k < 4; k++) inject(mk_body(6, k), 1'b0, k == 3);
        inject_idle();
        check_a_counts("after_truncated", 1, 0, 1);
        inject(mk_body(6, 1), 1'b0, 1'b0);
        inject_idle();
        check_a_counts("idle_drop", 1, 0, 2);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge noc_clk);
        loop_a   = 1'b1;
        tb_rdy_a = 1'b0;
        rst_a_n  = 1'b0;
        sb_a.delete();
        release_a(n);
        push_pkts_a(1, 0);
        run_a(0, 2, 100);
        @(posedge noc_clk);
        #2;
        rst_a_n = 1'b0;
        #1;
        tb_rdy_a = 1'b0;
        checks++;
        if ({a_if.sender_valid, a_if.sender_flit, a_if.sender_is_header, a_if.sender_is_tail,
             a_if.receive_ready, a_recv, a_send, a_err, a_done} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got=nonzero exp=0 (valid=%b flit=%h)",
                     a_if.sender_valid, a_if.sender_flit);
        end
        sb_a.delete();
        release_a(n);
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL reset_mid_header_edge got=%0d exp=17", n);
        end
        checks++;
        if (a_if.sender_flit !== mk_hdr(1, 1, 1, 1, 0, 4) || a_if.sender_is_header !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_header got=%h exp=%h", a_if.sender_flit, mk_hdr(1, 1, 1, 1, 0, 4));
        end
        check_a_counts("reset_mid", 0, 0, 0);
    endtask

    task automatic test_single_flit();
        int   n;
        int   popped;
        exp_t e, got;
        for (int i = 0; i < 260; i++) begin
            e.flit = mk_hdr(2, 2, 2, 2, i, 1);
            e.h    = 1'b1;
            e.t    = 1'b1;
            sb_b.push_back(e);
        end
        n = 0;
        @(negedge noc_clk);
        rst_b_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge noc_clk);
            #1;
            if (b_if.sender_valid) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL b_first_header_edge got=%0d exp=4", n);
        end
        popped = 0;
        for (int c = 0; c < 260; c++) begin
            got = {b_if.sender_flit, b_if.sender_is_header, b_if.sender_is_tail};
            checks++;
            if (b_if.sender_valid !== 1'b1) begin
                errors++;
                $display("FAIL b_valid_every_cycle[%0d] got=%b exp=1", c, b_if.sender_valid);
            end else if (b_if.sender_ready && sb_b.size() > 0) begin
                e = sb_b.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL flit_b[%0d] got=%h/%b/%b exp=%h/%b/%b",
                             popped, got.flit, got.h, got.t, e.flit, e.h, e.t);
                end
                popped++;
            end
            @(posedge noc_clk);
            #1;
        end
        repeat (2) @(negedge noc_clk);
        checks++;
        if (b_send !== 8'd255 || b_recv !== 8'd255 || b_err !== 8'd0) begin
            errors++;
            $display("FAIL b_saturate got=send%0d/recv%0d/err%0d exp=255/255/0", b_send, b_recv, b_err);
        end
        checks++;
        if (b_done !== 1'b0) begin
            errors++;
            $display("FAIL b_send_done got=%b exp=0", b_done);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_backpressure();
        test_wrong_dest();
        test_truncated();
        test_reset_mid();
        test_single_flit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
